id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between the decode stage and the execute stage, with integrated load-use hazard detection. Each cycle it captures the decoder's control bundles (WB, M, EX) and the decode-stage operands, and presents them to the execute stage. It inserts a one-cycle bubble on a load-use hazard or an external flush, and drives the write enables for the PC and the IF/ID register. It also keeps a saturating count of inserted bubbles for performance monitoring.

## Interface
Parameters:
- `BCNT_W`, default 16: width of the bubble counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `wb_i` input 2: {RegWrite, MemtoReg} from the decoder.
- `m_i` input 2: {MemRead, MemWrite} from the decoder.
- `ex_i` input 6: {RegDst, ALUSrc, ALUControl[3:0]} from the decoder.
- `rs_data_i`, `rt_data_i` input 32 each: register-file read data.
- `imm_i` input 32: sign-extended immediate.
- `pc4_i` input 32: PC+4 of the decode-stage instruction.
- `rs_i`, `rt_i`, `rd_i` input 5 each: register specifiers of the decode-stage instruction.
- `flush_i` input 1: kill the decode-stage instruction (taken branch or jump).
- `stall_i` input 1: global freeze (e.g. memory wait).
- `wb_o`, `m_o`, `ex_o`, `rs_data_o`, `rt_data_o`, `imm_o`, `pc4_o`, `rs_o`, `rt_o`, `rd_o` output: registered copies of the corresponding inputs, same widths.
- `valid_o` output 1: the execute-stage slot holds a real instruction.
- `hazard_o` output 1: load-use hazard detected this cycle (combinational).
- `pc_write_o` output 1: PC may update (combinational).
- `ifid_write_o` output 1: IF/ID register may update (combinational).
- `bubble_cnt_o` output `BCNT_W`: saturating count of inserted bubbles.

## Operation
Hazard detection:
- `hazard_o` = `m_o[1]` & `valid_o` & (`rt_o` != 0) & (`rt_o` == `rs_i` | `rt_o` == `rt_i`) & ~`flush_i`.
- The `rt_i` compare is unconditional. The resulting occasional spurious stall on I-type instructions is acceptable.

Write enables:
- `pc_write_o` = `ifid_write_o` = ~`stall_i` & ~`hazard_o`.

Per-edge action, highest priority first:
1. `stall_i`=1: hold all registers and the counter.
2. `flush_i`=1 or `hazard_o`=1: insert a bubble.
   - `wb_o`, `m_o`, `ex_o`, all data and specifier fields are cleared to 0.
   - `valid_o` is cleared to 0.
   - `bubble_cnt_o` increments, unless it is already all-ones.
3. Otherwise: load every field from its input and set `valid_o`=1.

Further rules:
- A bubble never has RegWrite, MemRead or MemWrite set. Downstream stages therefore need no `valid_o` qualification.
- Beq, Bne and Jump are resolved in decode and are not carried by this stage.
- `stall_i` and `flush_i` together: the hold wins. Upstream keeps `flush_i` asserted until `stall_i` drops.

## Timing
- Reset: all registered outputs are 0 immediately on `rst` assertion, independent of `clk`. This includes `valid_o`=0 and `bubble_cnt_o`=0.
- During reset, `hazard_o`=0 and `pc_write_o` = `ifid_write_o` = ~`stall_i`.
- Reset release: the first rising edge with `rst`=0 performs a normal load.
- Latency: 1 cycle from inputs to outputs.
- Load-use penalty: exactly 1 bubble.
  - After the bubble, `m_o[1]`=0, so `hazard_o` falls and the held instruction loads on the next edge.
- `hazard_o`, `pc_write_o` and `ifid_write_o` are combinational. They settle within the same cycle as input changes and have no registered delay.
- Counter saturates at 2^`BCNT_W`−1 and never wraps.
- Reset asserted mid-stall or mid-bubble: the state is discarded and the counter clears.

## Test plan
- Reset mid-operation:
  - Stimulus: load `wb_i`=2'b10, `ex_i`=6'b100010, `rs_data_i`=5, then assert `rst` mid-cycle.
  - Required: all outputs read 0 before the next edge; `valid_o`=0.
- Normal pass:
  - Stimulus: `wb_i`=2'b10, `m_i`=2'b00, `ex_i`=6'b100010, `rs_data_i`=32'h5, `rt_data_i`=32'h7, `rd_i`=9.
  - Required: next cycle the outputs equal those values, `valid_o`=1, `hazard_o`=0, `pc_write_o`=1.
- Load-use:
  - Stimulus: cycle n loads lw (`m_i`=2'b10, `rt_i`=8); cycle n+1 decode shows add with `rs_i`=8.
  - Required in cycle n+1: `hazard_o`=1, `pc_write_o`=0, `ifid_write_o`=0.
  - Required in cycle n+2: `wb_o`=0, `m_o`=0, `ex_o`=0, `valid_o`=0, `bubble_cnt_o`=1, `hazard_o`=0.
  - Required in cycle n+3: add present with `valid_o`=1.
- $0 and flush:
  - Stimulus: lw with `rt_i`=0 followed by a use of `rs_i`=0.
  - Required: `hazard_o`=0 and no bubble.
  - Stimulus: repeat the load-use case with `flush_i`=1 in cycle n+1.
  - Required: `hazard_o`=0 and `pc_write_o`=1; bubble inserted and `bubble_cnt_o` incremented once.
- Stall hold:
  - Stimulus: `stall_i`=1 for 3 cycles while the inputs change and `flush_i`=1.
  - Required: outputs and `bubble_cnt_o` are unchanged; `pc_write_o`=0 throughout.
- Counter saturation:
  - Stimulus: run with `BCNT_W`=4 and 20 consecutive flushes.
  - Required: `bubble_cnt_o` stops at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Pipeline register between decode (ID) and execute (EX). It captures the
// decoder's control bundles and operands and detects load-use hazards against
// the instruction currently in decode. On a hazard or flush it inserts one
// bubble in place of the decode-stage instruction. A global stall freezes all
// state. A saturating counter records how many bubbles were inserted.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   wb_i / wb_o         : {RegWrite, MemtoReg}
//   m_i  / m_o          : {MemRead, MemWrite}
//   ex_i / ex_o         : {RegDst, ALUSrc, ALUControl[3:0]}
//   rs_data_*, rt_data_*: register-file read data
//   imm_*, pc4_*        : sign-extended immediate, PC+4
//   rs_*, rt_*, rd_*    : register specifiers
//   flush_i             : kill the decode-stage instruction
//   stall_i             : global freeze (hold wins over flush)
//   valid_o             : EX slot holds a real instruction
//   hazard_o            : load-use hazard this cycle (combinational)
//   pc_write_o          : PC may update (combinational)
//   ifid_write_o        : IF/ID register may update (combinational)
//   bubble_cnt_o        : saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int BCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wb_i,
  input  logic [1:0]        m_i,
  input  logic [5:0]        ex_i,
  input  logic [31:0]       rs_data_i,
  input  logic [31:0]       rt_data_i,
  input  logic [31:0]       imm_i,
  input  logic [31:0]       pc4_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic [1:0]        wb_o,
  output logic [1:0]        m_o,
  output logic [5:0]        ex_o,
  output logic [31:0]       rs_data_o,
  output logic [31:0]       rt_data_o,
  output logic [31:0]       imm_o,
  output logic [31:0]       pc4_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic              valid_o,
  output logic              hazard_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic [BCNT_W-1:0] bubble_cnt_o
);

  // Everything that travels from ID to EX, so a bubble is a single '0 store.
  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [5:0]  ex;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } stage_t;

  stage_t            in_bundle;
  stage_t            stage_q;
  logic              valid_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic              bubble;

  assign in_bundle = {wb_i, m_i, ex_i, rs_data_i, rt_data_i, imm_i, pc4_i,
                      rs_i, rt_i, rd_i};

  // Load in EX whose destination (rt) is read by the decode instruction.
  // The rt compare is unconditional; an occasional spurious stall on I-type
  // instructions is accepted. A flush kills the consumer, so no hazard then.
  assign hazard_o = stage_q.m[1] & valid_q & (stage_q.rt != 5'd0) &
                    ((stage_q.rt == rs_i) | (stage_q.rt == rt_i)) & ~flush_i;

  assign pc_write_o   = ~stall_i & ~hazard_o;
  assign ifid_write_o = ~stall_i & ~hazard_o;
  assign bubble       = flush_i | hazard_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: every register is in the async reset, so a reset asserted mid-stall
  // or mid-bubble leaves no stale control bits behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      valid_q <= 1'b0;
      bcnt_q  <= '0;
    end else if (!stall_i) begin
      if (bubble) begin
        stage_q <= '0;
        valid_q <= 1'b0;
        if (~&bcnt_q) bcnt_q <= bcnt_q + BCNT_W'(1);
      end else begin
        stage_q <= in_bundle;
        valid_q <= 1'b1;
      end
    end
  end

  assign wb_o         = stage_q.wb;
  assign m_o          = stage_q.m;
  assign ex_o         = stage_q.ex;
  assign rs_data_o    = stage_q.rs_data;
  assign rt_data_o    = stage_q.rt_data;
  assign imm_o        = stage_q.imm;
  assign pc4_o        = stage_q.pc4;
  assign rs_o         = stage_q.rs;
  assign rt_o         = stage_q.rt;
  assign rd_o         = stage_q.rd;
  assign valid_o      = valid_q;
  assign bubble_cnt_o = bcnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage (BCNT_W = 4 so saturation is reachable).
// A reference model holds the expected EX-slot contents as a whole record and
// advances it by the stage rules: hold on stall, bubble on flush or load-use,
// otherwise load.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int BW = 4;

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [5:0]  ex;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } fields_t;

  typedef struct packed {
    fields_t       f;
    logic          valid;
    logic [BW-1:0] cnt;
  } snap_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    stall = 1'b0;
  logic    flush = 1'b0;
  fields_t in_f = '0;

  logic [1:0]    wb_o, m_o;
  logic [5:0]    ex_o;
  logic [31:0]   rs_data_o, rt_data_o, imm_o, pc4_o;
  logic [4:0]    rs_o, rt_o, rd_o;
  logic          valid_o, hazard_o, pc_write_o, ifid_write_o;
  logic [BW-1:0] bubble_cnt_o;

  snap_t obs;
  snap_t exp_s = '0;
  int    passed = 0;
  int    total  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.BCNT_W(BW)) dut (
    .clk(clk), .rst(rst),
    .wb_i(in_f.wb), .m_i(in_f.m), .ex_i(in_f.ex),
    .rs_data_i(in_f.rs_data), .rt_data_i(in_f.rt_data),
    .imm_i(in_f.imm), .pc4_i(in_f.pc4),
    .rs_i(in_f.rs), .rt_i(in_f.rt), .rd_i(in_f.rd),
    .flush_i(flush), .stall_i(stall),
    .wb_o(wb_o), .m_o(m_o), .ex_o(ex_o),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
    .imm_o(imm_o), .pc4_o(pc4_o),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
    .valid_o(valid_o), .hazard_o(hazard_o),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always_comb begin
    obs = '0;
    obs.f = {wb_o, m_o, ex_o, rs_data_o, rt_data_o, imm_o, pc4_o,
             rs_o, rt_o, rd_o};
    obs.valid = valid_o;
    obs.cnt   = bubble_cnt_o;
  end

  // ---------------- reference model ----------------
  function automatic bit model_hazard(snap_t cur, fields_t nxt, bit fl);
    return cur.f.m[1] && cur.valid && (cur.f.rt != 0) &&
           (cur.f.rt == nxt.rs || cur.f.rt == nxt.rt) && !fl;
  endfunction

  function automatic snap_t model_next(snap_t cur, fields_t nxt, bit st, bit fl);
    snap_t r;
    r = cur;
    if (st) return r;
    if (fl || model_hazard(cur, nxt, fl)) begin
      r.f     = '0;
      r.valid = 1'b0;
      r.cnt   = (cur.cnt == {BW{1'b1}}) ? cur.cnt : cur.cnt + 1'b1;
    end else begin
      r.f     = nxt;
      r.valid = 1'b1;
    end
    return r;
  endfunction

  function automatic fields_t rand_fields();
    fields_t r;
    r.wb      = 2'($urandom);
    r.m       = 2'($urandom);
    r.ex      = 6'($urandom);
    r.rs_data = $urandom;
    r.rt_data = $urandom;
    r.imm     = $urandom;
    r.pc4     = $urandom;
    r.rs      = 5'($urandom_range(0, 3));
    r.rt      = 5'($urandom_range(0, 3));
    r.rd      = 5'($urandom_range(0, 31));
    return r;
  endfunction

  // Advance one rising edge and move the model with it. Called just after a
  // rising edge; returns 1 ns after the next one.
  task automatic tick();
    snap_t nxt;
    nxt = model_next(exp_s, in_f, stall, flush);
    @(posedge clk);
    #1;
    exp_s = nxt;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_f    = '0;
    in_f.wb = 2'b10;
    in_f.ex = 6'b100010;
    in_f.rs_data = 32'd5;
    tick();
    total++; if (obs !== exp_s) $display("FAIL reset_preload: got %h want %h", obs, exp_s); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (obs !== '0) $display("FAIL reset_async_clear: got %h want 0", obs); else passed++;
    total++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else passed++;
    stall = 1'b1;
    #1;
    total++; if ({hazard_o, pc_write_o, ifid_write_o} !== 3'b000)
      $display("FAIL reset_stall_we: got %b want 000", {hazard_o, pc_write_o, ifid_write_o}); else passed++;
    stall = 1'b0;
    @(posedge clk); #1;
    total++; if (obs !== '0) $display("FAIL reset_hold_edge: got %h want 0", obs); else passed++;
    total++; if ({hazard_o, pc_write_o, ifid_write_o} !== 3'b011)
      $display("FAIL reset_we: got %b want 011", {hazard_o, pc_write_o, ifid_write_o}); else passed++;
    @(negedge clk);
    rst   = 1'b0;
    exp_s = '0;
    @(posedge clk); #1;
    exp_s = model_next(exp_s, in_f, stall, flush);
    total++; if (obs !== exp_s) $display("FAIL reset_release_load: got %h want %h", obs, exp_s); else passed++;
  endtask

  task automatic test_normal();
    in_f = '0;
    in_f.wb = 2'b10; in_f.m = 2'b00; in_f.ex = 6'b100010;
    in_f.rs_data = 32'h5; in_f.rt_data = 32'h7; in_f.rd = 5'd9;
    @(negedge clk);
    total++; if ({hazard_o, pc_write_o} !== 2'b01)
      $display("FAIL normal_we: got %b want 01", {hazard_o, pc_write_o}); else passed++;
    tick();
    total++; if (obs !== exp_s) $display("FAIL normal_regs: got %h want %h", obs, exp_s); else passed++;
    total++; if ({wb_o, ex_o, rs_data_o, rt_data_o, rd_o, valid_o} !== {2'b10, 6'b100010, 32'h5, 32'h7, 5'd9, 1'b1})
      $display("FAIL normal_fields: got wb=%b ex=%b rs=%h rt=%h rd=%0d v=%b want 10 100010 5 7 9 1",
               wb_o, ex_o, rs_data_o, rt_data_o, rd_o, valid_o); else passed++;
  endtask

  task automatic test_load_use();
    logic [BW-1:0] c0;
    in_f = rand_fields();
    in_f.m = 2'b10; in_f.wb = 2'b11; in_f.rt = 5'd8; in_f.rs = 5'd1;
    tick();
    c0 = exp_s.cnt;
    in_f = rand_fields();
    in_f.m = 2'b00; in_f.wb = 2'b10; in_f.rs = 5'd8; in_f.rt = 5'd2;
    @(negedge clk);
    total++; if ({hazard_o, pc_write_o, ifid_write_o} !== 3'b100)
      $display("FAIL loaduse_detect: got %b want 100", {hazard_o, pc_write_o, ifid_write_o}); else passed++;
    tick();
    total++; if (obs !== exp_s) $display("FAIL loaduse_bubble: got %h want %h", obs, exp_s); else passed++;
    total++; if ({wb_o, m_o, ex_o, valid_o, hazard_o} !== 12'd0)
      $display("FAIL loaduse_bubble_ctl: got %b want 0", {wb_o, m_o, ex_o, valid_o, hazard_o}); else passed++;
    total++; if (bubble_cnt_o !== BW'(c0 + 1'b1))
      $display("FAIL loaduse_cnt: got %0d want %0d", bubble_cnt_o, c0 + 1'b1); else passed++;
    tick();
    total++; if ({valid_o, rs_o, obs.f} !== {1'b1, 5'd8, in_f})
      $display("FAIL loaduse_release: got v=%b rs=%0d f=%h want v=1 rs=8 f=%h", valid_o, rs_o, obs.f, in_f); else passed++;
  endtask

  task automatic test_zero_flush();
    logic [BW-1:0] c0;
    in_f = rand_fields();
    in_f.m = 2'b10; in_f.rt = 5'd0; in_f.rs = 5'd3;
    tick();
    c0 = exp_s.cnt;
    in_f = rand_fields();
    in_f.m = 2'b00; in_f.rs = 5'd0; in_f.rt = 5'd0;
    @(negedge clk);
    total++; if (hazard_o !== 1'b0) $display("FAIL zero_reg_hazard: got %b want 0", hazard_o); else passed++;
    tick();
    total++; if ({valid_o, bubble_cnt_o} !== {1'b1, c0})
      $display("FAIL zero_reg_nobubble: got v=%b cnt=%0d want v=1 cnt=%0d", valid_o, bubble_cnt_o, c0); else passed++;
    // load-use with a simultaneous flush
    in_f = rand_fields();
    in_f.m = 2'b10; in_f.rt = 5'd8;
    tick();
    c0 = exp_s.cnt;
    in_f = rand_fields();
    in_f.rs = 5'd8;
    flush = 1'b1;
    @(negedge clk);
    total++; if ({hazard_o, pc_write_o} !== 2'b01)
      $display("FAIL flush_we: got %b want 01", {hazard_o, pc_write_o}); else passed++;
    tick();
    flush = 1'b0;
    total++; if ({valid_o, bubble_cnt_o, obs.f} !== {1'b0, BW'(c0 + 1'b1), fields_t'('0)})
      $display("FAIL flush_bubble: got v=%b cnt=%0d want v=0 cnt=%0d", valid_o, bubble_cnt_o, c0 + 1'b1); else passed++;
  endtask

  task automatic test_stall();
    snap_t held;
    in_f = rand_fields();
    in_f.m = 2'b00;
    tick();
    held  = exp_s;
    stall = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_f = rand_fields();
      @(negedge clk);
      total++; if ({pc_write_o, ifid_write_o} !== 2'b00)
        $display("FAIL stall_we[%0d]: got %b want 00", i, {pc_write_o, ifid_write_o}); else passed++;
      tick();
      total++; if (obs !== held) $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, held); else passed++;
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_f  = rand_fields();
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      total++; if ({hazard_o, pc_write_o, ifid_write_o} !==
                   {model_hazard(exp_s, in_f, flush), {2{!stall && !model_hazard(exp_s, in_f, flush)}}})
        $display("FAIL rand_comb[%0d]: got %b", i, {hazard_o, pc_write_o, ifid_write_o}); else passed++;
      tick();
      total++; if (obs !== exp_s) $display("FAIL rand_regs[%0d]: got %h want %h", i, obs, exp_s); else passed++;
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_s = '0;
    total++; if (bubble_cnt_o !== '0) $display("FAIL sat_reset_cnt: got %0d want 0", bubble_cnt_o); else passed++;
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_f = rand_fields();
      tick();
      total++; if (bubble_cnt_o !== exp_s.cnt)
        $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bubble_cnt_o, exp_s.cnt); else passed++;
    end
    flush = 1'b0;
    total++; if (bubble_cnt_o !== 4'd15) $display("FAIL sat_final: got %0d want 15", bubble_cnt_o); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_s = model_next('0, in_f, 1'b0, 1'b0);
    test_reset();
    test_normal();
    test_load_use();
    test_zero_flush();
    test_stall();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
